// File: rtl/out_uart_tx.sv
// Serial 8N1 transmitter fed by the core's OUTPUT port: toggle-detected byte
// enqueue, small circular FIFO, and a START/DATA/STOP shifter with back-to-back frames.
module out_uart_tx #(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic [7:0]                    OUT_DATA,
   input  logic                          OUT_TOGGLE,
   input  logic                          OVF_CLR,
   output logic                          TX,
   output logic                          FIFO_FULL,
   output logic                          FIFO_EMPTY,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
   output logic                          TX_BUSY,
   output logic                          OVERFLOW,
   output logic [1:0]                    state_dbg
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state;
   logic            t1, t2;
   logic            push, pop, push_ok, drop;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [BW-1:0]   baud;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            tx_q, busy_q, ovf_q;

   // Two-flop edge detect: every level change of OUT_TOGGLE is one push.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         t1 <= 1'b0;
         t2 <= 1'b0;
      end else begin
         t1 <= OUT_TOGGLE;
         t2 <= t1;
      end
   end

   assign push = t1 ^ t2;
   assign pop  = (count != '0) && ((state == IDLE) || ((state == STOP) && (baud == '0)));
   // A pop on the same edge frees the slot, so a push while full is still accepted.
   assign push_ok = push && (!FIFO_FULL || pop);
   assign drop    = push && FIFO_FULL && !pop;

   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem[wr_ptr] <= OUT_DATA;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push_ok) - CW'(pop);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end else if (OVF_CLR) begin
         ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shreg   <= mem[rd_ptr];
                  bit_idx <= '0;
                  baud    <= BAUD_MAX;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               if (baud == '0) begin
                  baud  <= BAUD_MAX;
                  tx_q  <= shreg[0];
                  state <= DATA;
               end else begin
                  baud <= baud - BW'(1);
               end
            end
            DATA: begin
               if (baud == '0) begin
                  baud <= BAUD_MAX;
                  if (bit_idx == 3'd7) begin
                     tx_q  <= 1'b1;
                     state <= STOP;
                  end else begin
                     shreg   <= {1'b0, shreg[7:1]};
                     tx_q    <= shreg[1];
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  baud <= baud - BW'(1);
               end
            end
            STOP: begin
               if (baud == '0) begin
                  if (pop) begin
                     shreg   <= mem[rd_ptr];
                     bit_idx <= '0;
                     baud    <= BAUD_MAX;
                     tx_q    <= 1'b0;
                     state   <= START;
                  end else begin
                     tx_q   <= 1'b1;
                     busy_q <= 1'b0;
                     state  <= IDLE;
                  end
               end else begin
                  baud <= baud - BW'(1);
               end
            end
            default: begin
               state  <= IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign TX         = tx_q;
   assign TX_BUSY    = busy_q;
   assign OVERFLOW   = ovf_q;
   assign FIFO_COUNT = count;
   assign FIFO_FULL  = (count == CW'(FIFO_DEPTH));
   assign FIFO_EMPTY = (count == '0);
   assign state_dbg  = state;

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: queue-based frame model checked every cycle, plus
// directed scenarios with hand-computed literal expectations and random traffic.
module tb_out_uart_tx;

   localparam int DIV   = 4;
   localparam int DEPTH = 8;
   localparam int FRAME = 10 * DIV;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [7:0] OUT_DATA;
   logic       OUT_TOGGLE;
   logic       OVF_CLR;
   logic       TX, FIFO_FULL, FIFO_EMPTY, TX_BUSY, OVERFLOW;
   logic [3:0] FIFO_COUNT;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;

   out_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST_N(RST_N), .OUT_DATA(OUT_DATA), .OUT_TOGGLE(OUT_TOGGLE),
      .OVF_CLR(OVF_CLR), .TX(TX), .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY),
      .FIFO_COUNT(FIFO_COUNT), .TX_BUSY(TX_BUSY), .OVERFLOW(OVERFLOW),
      .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 CLK = ~CLK;

   initial begin
      #900000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Model: bytes waiting in exp_q; the frame on the wire is a 10-bit vector
   // {stop, data, start} played out DIV cycles per bit.
   logic [7:0] exp_q[$];
   logic [9:0] m_frame;
   int         m_cyc;
   bit         m_busy, m_ovf, m_t1, m_t2;

   always @(posedge CLK or negedge RST_N) begin
      bit         push_now, pop_now, dropped;
      logic [7:0] pb;
      if (!RST_N) begin
         exp_q.delete();
         m_frame = '1;
         m_cyc   = 0;
         m_busy  = 1'b0;
         m_ovf   = 1'b0;
         m_t1    = 1'b0;
         m_t2    = 1'b0;
      end else begin
         push_now = m_t1 ^ m_t2;
         pop_now  = (exp_q.size() > 0) && (!m_busy || m_cyc == FRAME - 1);
         dropped  = 1'b0;
         if (m_busy && m_cyc == FRAME - 1) m_busy = 1'b0;
         else if (m_busy) m_cyc++;
         if (pop_now) begin
            pb      = exp_q.pop_front();
            m_frame = {1'b1, pb, 1'b0};
            m_cyc   = 0;
            m_busy  = 1'b1;
         end
         if (push_now) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(OUT_DATA);
            else dropped = 1'b1;
         end
         if (dropped) m_ovf = 1'b1;
         else if (OVF_CLR) m_ovf = 1'b0;
         m_t2 = m_t1;
         m_t1 = OUT_TOGGLE;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // scoreboard compare, every cycle away from the active edge
   always @(negedge CLK) begin
      check("tx",    32'(TX),         32'(m_busy ? m_frame[m_cyc / DIV] : 1'b1));
      check("busy",  32'(TX_BUSY),    32'(m_busy));
      check("count", 32'(FIFO_COUNT), 32'(exp_q.size()));
      check("full",  32'(FIFO_FULL),  32'(exp_q.size() == DEPTH));
      check("empty", 32'(FIFO_EMPTY), 32'(exp_q.size() == 0));
      check("ovf",   32'(OVERFLOW),   32'(m_ovf));
   end

   // driver tasks: all start and end just after a falling edge
   task automatic flip(input logic [7:0] d, input int gap);
      OUT_DATA   = d;
      OUT_TOGGLE = ~OUT_TOGGLE;
      repeat (gap) @(negedge CLK);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((m_busy || exp_q.size() != 0) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL wait_idle act=busy exp=idle budget=%0d", budget);
      end
      repeat (3) @(negedge CLK);
   endtask

   task automatic wait_cyc(input int target, input int budget);
      int n = 0;
      while (!(m_busy && m_cyc == target) && n < budget) begin
         @(negedge CLK);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL wait_cyc act=none exp=%0d", target);
      end
   endtask

   initial begin
      int seq[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
      int first_low, busy_n, bad, max_cnt, low_n, exp_bit;

      RST_N = 1'b0; OUT_DATA = 8'h00; OUT_TOGGLE = 1'b0; OVF_CLR = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_tx", 32'(TX), 32'd1);
      check("rst_empty", 32'(FIFO_EMPTY), 32'd1);
      check("rst_full", 32'(FIFO_FULL), 32'd0);
      check("rst_busy", 32'(TX_BUSY), 32'd0);
      check("rst_ovf", 32'(OVERFLOW), 32'd0);
      check("rst_count", 32'(FIFO_COUNT), 32'd0);
      #2 RST_N = 1'b1;
      @(negedge CLK);
      repeat (2) @(negedge CLK);

      // single byte 0x55: literal waveform
      OUT_DATA = 8'h55; OUT_TOGGLE = ~OUT_TOGGLE;
      first_low = -1; busy_n = 0; bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (TX === 1'b0 && first_low < 0) first_low = i;
         if (TX_BUSY === 1'b1) busy_n++;
         if (i < 2 || i > 41) exp_bit = 1;
         else exp_bit = seq[(i - 2) / 4];
         if (TX !== 1'(exp_bit)) bad++;
      end
      check("single_first_low", 32'(first_low), 32'd2);
      check("single_busy_len", 32'(busy_n), 32'd40);
      check("single_wave_bad", 32'(bad), 32'd0);
      wait_idle(200);

      // back-to-back 0xA3 / 0x0F
      flip(8'hA3, 2);
      OUT_DATA = 8'h0F; OUT_TOGGLE = ~OUT_TOGGLE;
      max_cnt = 0; busy_n = 0;
      for (int i = 0; i < 90; i++) begin
         @(negedge CLK);
         if (int'(FIFO_COUNT) > max_cnt) max_cnt = int'(FIFO_COUNT);
         if (TX_BUSY === 1'b1) busy_n++;
      end
      check("b2b_peak_count", 32'(max_cnt), 32'd1);
      check("b2b_busy_len", 32'(busy_n), 32'd80);
      wait_idle(200);

      // repeated data
      flip(8'h7E, 2);
      flip(8'h7E, 2);
      wait_idle(200);

      // overflow with a frame in progress
      flip(8'hC6, 3);
      for (int k = 1; k <= 9; k++) begin
         flip(8'(k), 2);
         if (k == 8) check("ovf_full_after_8", 32'(FIFO_FULL), 32'd1);
         if (k == 9) check("ovf_set_after_9", 32'(OVERFLOW), 32'd1);
      end
      OVF_CLR = 1'b1;
      @(negedge CLK);
      OVF_CLR = 1'b0;
      check("ovf_cleared", 32'(OVERFLOW), 32'd0);

      // push landing on the STOP->START pop edge while full
      wait_cyc(FRAME - 2, 200);
      flip(8'hE7, 2);
      check("simul_count", 32'(FIFO_COUNT), 32'd8);
      check("simul_ovf", 32'(OVERFLOW), 32'd0);
      check("simul_full", 32'(FIFO_FULL), 32'd1);
      wait_idle(1000);

      // reset during data bit 3
      flip(8'h3C, 2);
      flip(8'h99, 2);
      wait_cyc(4 * DIV + 1, 200);
      #2 RST_N = 1'b0; OUT_TOGGLE = 1'b0;
      #1;
      check("midrst_tx", 32'(TX), 32'd1);
      check("midrst_empty", 32'(FIFO_EMPTY), 32'd1);
      check("midrst_busy", 32'(TX_BUSY), 32'd0);
      repeat (3) @(negedge CLK);
      #2 RST_N = 1'b1;
      low_n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (TX !== 1'b1) low_n++;
      end
      check("midrst_no_frame", 32'(low_n), 32'd0);

      // reset released with toggle held high: exactly one frame
      @(negedge CLK);
      #2 RST_N = 1'b0; OUT_TOGGLE = 1'b1; OUT_DATA = 8'hB4;
      repeat (2) @(negedge CLK);
      #2 RST_N = 1'b1;
      busy_n = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge CLK);
         if (TX_BUSY === 1'b1) busy_n++;
      end
      check("held_toggle_one_frame", 32'(busy_n), 32'd40);
      wait_idle(200);

      // random traffic
      for (int n = 0; n < 60; n++) begin
         int gap;
         gap = $urandom_range(2, 60);
         OUT_DATA = 8'($urandom_range(0, 255));
         OUT_TOGGLE = ~OUT_TOGGLE;
         for (int g = 0; g < gap; g++) begin
            OVF_CLR = ($urandom_range(0, 15) == 0);
            @(negedge CLK);
         end
         OVF_CLR = 1'b0;
      end
      wait_idle(3000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
